// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue
// Purpose  : Instruction fetch front end. Owns the fetch PC, issues word
//            reads over a req/ack handshake with at most one outstanding
//            request, and buffers {instruction, PC} pairs in a small FIFO
//            feeding decode. Redirects flush the queue and restart fetch;
//            an in-flight stale read is drained in DROP and discarded.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [31:0]        c_NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_req, w_req_nxt;
    logic [31:0]          r_addr, w_addr_nxt;
    logic [31:0]          r_fetch_pc, w_fetch_pc_nxt;
    logic [c_PTR_W-1:0]   r_wptr, r_rptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   w_occ_after;
    logic [31:0]          r_mem_inst [DEPTH];
    logic [31:0]          r_mem_pc   [DEPTH];
    logic                 w_ack, w_pop, w_push, w_clear;
    logic [31:0]          w_redirect_pc;
    logic                 w_unused;

    // Acks only count while a request is actually on the bus.
    assign w_ack         = imem_ack & r_req;
    assign w_pop         = out_valid & out_ready;
    assign w_redirect_pc = {redirect_addr[31:2], 2'b00};
    assign w_unused      = ^redirect_addr[1:0];

    // Occupancy after this edge in the non-redirect REQ case, where a push
    // happens exactly when an ack arrives.
    assign w_occ_after = r_count + c_CNT_W'(w_ack) - c_CNT_W'(w_pop);

    // Next-state, request issue and fetch PC update.
    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_addr_nxt     = r_addr;
        w_fetch_pc_nxt = r_fetch_pc;
        w_push         = 1'b0;
        w_clear        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
                w_req_nxt   = 1'b1;
                w_addr_nxt  = r_fetch_pc;
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    w_clear        = 1'b1;
                    w_fetch_pc_nxt = w_redirect_pc;
                    if (!r_req || w_ack) begin
                        w_req_nxt  = 1'b1;
                        w_addr_nxt = w_redirect_pc;
                    end else begin
                        // Request in flight cannot be withdrawn: drain it.
                        w_state_nxt = ST_DROP;
                    end
                end else begin
                    if (w_ack) begin
                        w_push         = 1'b1;
                        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    end
                    if (!r_req || w_ack) begin
                        w_req_nxt  = (w_occ_after < c_DEPTH);
                        w_addr_nxt = w_fetch_pc_nxt;
                    end
                end
            end
            ST_DROP: begin
                if (redirect_valid) begin
                    w_clear        = 1'b1;
                    w_fetch_pc_nxt = w_redirect_pc;
                end
                // Queue is empty here, so the restart always has room.
                if (w_ack) begin
                    w_state_nxt = ST_REQ;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = w_fetch_pc_nxt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            r_addr     <= w_addr_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    // FIFO pointers and occupancy; a flush overrides any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are only visible while occupancy is nonzero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wptr] <= imem_rdata;
            r_mem_pc[r_wptr]   <= r_addr;
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign out_valid = (r_count != '0);
    assign out_inst  = out_valid ? r_mem_inst[r_rptr] : c_NOP;
    assign out_pc    = out_valid ? r_mem_pc[r_rptr]   : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_queue
// Purpose  : Self-checking bench for inst_fetch_queue. A memory responder
//            with configurable/random latency answers reads with
//            addr ^ key; a stream scoreboard expects the decode side to see
//            consecutive PCs starting at reset PC or at each redirect target.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          waited;
    int          lat;
    int          pops;
    logic        mem_override;
    logic        mem_rand;
    logic [31:0] mem_key;
    logic [31:0] exp_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Memory responder: acks after `lat` waiting cycles with addr ^ key.
    task automatic mem_drive();
        if (mem_override) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end else if (imem_req && !rst) begin
            if (waited >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr ^ mem_key;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
            end
            waited++;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
        end
    endtask

    // One clock: update the stream model, check the handshake, drive memory.
    task automatic tick();
        logic        p_valid, p_ready, p_redir, p_req, p_ack, p_rst;
        logic [31:0] p_addr, p_raddr;
        p_valid = out_valid;  p_ready = out_ready;  p_redir = redirect_valid;
        p_raddr = redirect_addr;  p_req = imem_req;  p_ack = imem_ack;
        p_addr  = imem_addr;  p_rst = rst;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        if (!p_rst && !rst) begin
            if (p_redir) begin
                exp_pc = {p_raddr[31:2], 2'b00};
            end else if (p_valid && p_ready) begin
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (p_req && !p_ack) begin
                chk1("hold_req", imem_req, 1'b1);
                chk("hold_addr", imem_addr, p_addr);
            end
            if (p_redir) chk1("flush_valid", out_valid, 1'b0);
        end
        if (p_req && p_ack) begin
            waited = 0;
            if (mem_rand) lat = int'($urandom_range(0, 3));
        end
        mem_drive();
        if (out_valid) begin
            chk("head_pc", out_pc, exp_pc);
            chk("head_inst", out_inst, exp_pc ^ mem_key);
        end else begin
            chk("idle_inst", out_inst, NOP);
            chk("idle_pc", out_pc, 32'h0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_req"}, imem_req, 1'b0);
        chk({tag, "_addr"}, imem_addr, RESET_PC);
        chk1({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_inst"}, out_inst, NOP);
        chk({tag, "_pc"}, out_pc, 32'h0);
    endtask

    task automatic do_reset(input logic ready, input int latency, input logic [31:0] key);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        out_ready      = ready;
        mem_override   = 1'b0;
        mem_rand       = 1'b0;
        mem_key        = key;
        lat            = latency;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check_reset_outputs("rst");
        rst    = 1'b0;
        exp_pc = RESET_PC;
        waited = 0;
        mem_drive();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pops = 0;

        // Zero-wait memory, rdata = addr, decode always ready.
        do_reset(1'b1, 0, 32'h0);
        tick();
        chk1("t1_e1_req", imem_req, 1'b1);
        chk("t1_e1_addr", imem_addr, RESET_PC);
        chk1("t1_e1_valid", out_valid, 1'b0);
        tick();
        chk1("t1_e2_valid", out_valid, 1'b1);
        chk("t1_e2_pc", out_pc, 32'h0);
        chk("t1_e2_inst", out_inst, 32'h0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk1("t1_valid", out_valid, 1'b1);
            chk("t1_pc", out_pc, 32'(i * 4));
            chk("t1_inst", out_inst, 32'(i * 4));
        end

        // Decode stalled from the start: queue fills, fetch stops, resumes.
        do_reset(1'b0, 0, 32'h1357_9BDF);
        for (int i = 0; i < 5; i++) tick();
        chk1("t2_full_req", imem_req, 1'b0);
        chk1("t2_full_valid", out_valid, 1'b1);
        chk("t2_full_pc", out_pc, 32'h0);
        tick();
        tick();
        chk1("t2_stay_idle_req", imem_req, 1'b0);
        out_ready = 1'b1;
        tick();
        chk1("t2_resume_req", imem_req, 1'b1);
        chk("t2_resume_addr", imem_addr, 32'h10);
        chk("t2_resume_pc", out_pc, 32'h4);
        for (int i = 0; i < 8; i++) tick();
        chk("t2_stream_pc", out_pc, 32'h24);

        // 3-cycle memory; redirect while the read of 0x8 is in flight.
        do_reset(1'b1, 3, 32'h0F0F_1234);
        for (int i = 0; i < 40 && !(imem_req && imem_addr == 32'h8); i++) tick();
        chk1("t3_reach8", imem_req && imem_addr == 32'h8, 1'b1);
        tick();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0100;
        tick();
        chk1("t3_drop_req", imem_req, 1'b1);
        chk("t3_drop_addr", imem_addr, 32'h8);
        for (int i = 0; i < 10 && !(imem_req && imem_addr == 32'h100); i++) tick();
        chk("t3_restart_addr", imem_addr, 32'h100);
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        chk1("t3_new_valid", out_valid, 1'b1);
        chk("t3_new_pc", out_pc, 32'h100);

        // Redirect coincident with ack and pop, two entries queued.
        do_reset(1'b0, 0, 32'h2468_ACE0);
        tick();
        tick();
        tick();
        chk1("t4_pre_valid", out_valid, 1'b1);
        chk("t4_pre_pc", out_pc, 32'h0);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_0202;
        tick();
        chk1("t4_flush_valid", out_valid, 1'b0);
        chk1("t4_req", imem_req, 1'b1);
        chk("t4_addr", imem_addr, 32'h200);
        tick();
        chk1("t4_new_valid", out_valid, 1'b1);
        chk("t4_new_pc", out_pc, 32'h200);

        // Fetch PC wrap at the top of the address space.
        do_reset(1'b1, 0, 32'h5555_AAAA);
        for (int i = 0; i < 3; i++) tick();
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFF8;
        tick();
        chk("t5_addr", imem_addr, 32'hFFFF_FFF8);
        tick();
        chk("t5_pc0", out_pc, 32'hFFFF_FFF8);
        tick();
        chk("t5_pc1", out_pc, 32'hFFFF_FFFC);
        tick();
        chk1("t5_wrap_valid", out_valid, 1'b1);
        chk("t5_pc2", out_pc, 32'h0000_0000);

        // Asynchronous reset while a read is outstanding; ack during reset.
        do_reset(1'b1, 3, 32'h0BAD_F00D);
        tick();
        tick();
        chk1("t6_outstanding", imem_req, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        mem_override = 1'b1;
        mem_drive();
        tick();
        tick();
        rst    = 1'b0;
        exp_pc = RESET_PC;
        waited = 0;
        tick();
        chk1("t6_e1_req", imem_req, 1'b1);
        chk("t6_e1_addr", imem_addr, RESET_PC);
        chk1("t6_e1_valid", out_valid, 1'b0);
        mem_override = 1'b0;
        mem_drive();
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        chk1("t6_first_valid", out_valid, 1'b1);
        chk("t6_first_pc", out_pc, RESET_PC);

        // Random traffic against the stream model.
        do_reset(1'b1, 0, $urandom);
        mem_rand = 1'b1;
        tick();
        pops = 0;
        for (int i = 0; i < 2000; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) < 4) begin
                redirect_valid = 1'b1;
                if ($urandom_range(0, 3) == 0)
                    redirect_addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else
                    redirect_addr = $urandom;
            end
            tick();
        end
        chk1("rand_progress", pops > 100, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch front end for the pipelined core. Owns the fetch PC, issues word reads to instruction memory over a req/ack handshake, and buffers returned instructions with their PCs in a small FIFO feeding the IF/ID stage register. Jump/branch/ecall redirects from writeback flush the queue and restart fetch, so the core no longer gates PC updates with ad-hoc stall flags.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- redirect_valid  in  1  flush and restart fetch this cycle
- redirect_addr  in  32  new fetch PC; bits [1:0] ignored (treated as 0)
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  word-aligned read address
- imem_ack  in  1  read data valid; sampled only while imem_req=1
- imem_rdata  in  32  instruction word, valid with imem_ack
- out_valid  out  1  FIFO head valid
- out_inst  out  32  head instruction; 32'h0000_0013 (NOP) when out_valid=0
- out_pc  out  32  PC of head instruction; 0 when out_valid=0
- out_ready  in  1  decode accepts head (pop when out_valid & out_ready)

## Operation
- FSM states: IDLE, REQ, DROP.
- IDLE: entered only by reset; next edge -> REQ with imem_req=1, imem_addr=RESET_PC.
- REQ, imem_req=1: hold imem_addr and imem_req until ack. On ack: push {imem_rdata, imem_addr}; fetch_pc += 4 (mod 2^32, 0xFFFF_FFFC -> 0). Next request issued immediately (req stays 1, addr updated) if occupancy after this edge's push/pop < DEPTH, else imem_req=0.
- REQ, imem_req=0: re-assert imem_req at fetch_pc on the edge where occupancy after pop < DEPTH.
- At most one outstanding request; a request once raised is never withdrawn before ack.
- Redirect (highest priority, any state except IDLE): at the edge, FIFO cleared, pop ignored, any same-edge ack data discarded, fetch_pc = {redirect_addr[31:2],2'b00}.
  - No request outstanding, or ack at same edge: next state REQ, imem_req=1, imem_addr=new PC.
  - Request outstanding, no ack: next state DROP; imem_req/imem_addr held at old values.
- DROP: wait for ack; data discarded, no push; next state REQ at fetch_pc. Redirect in DROP updates fetch_pc, stays DROP.
- Occupancy counter 0..DEPTH; read/write pointers log2(DEPTH) bits, wrap naturally. Push when full cannot occur (issue rule guarantees space); simultaneous push+pop keeps occupancy.

## Timing
- Reset values: state=IDLE, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_inst=NOP, out_pc=0, occupancy=0, fetch_pc=RESET_PC. Applied immediately on rst assertion.
- E1 (first edge after rst deassert): imem_req=1. Zero-wait memory acks at E2 -> out_valid=1 after E2. Latency: ack edge to out_valid = 1 cycle.
- Sustained throughput with zero-wait memory and out_ready=1: one instruction per cycle.
- out_valid/out_inst/out_pc driven from FIFO head registers; change only on edges.
- Redirect edge -> out_valid=0 for at least the next cycle; first new-path instruction visible one cycle after its ack.
- Late ack arriving after reset (state IDLE) ignored.

## Test plan
- Reset, zero-wait memory returning rdata=addr, out_ready=1 -> out_valid rises after E2; out_pc/out_inst 0,4,8,12 on consecutive cycles.
- out_ready=0 from start -> exactly 4 pushes (0x0–0xC), imem_req=0 afterwards; set out_ready=1 -> pops 0x0.., fetch resumes at 0x10, no gap/duplicate.
- 3-cycle ack latency, redirect to 0x100 one cycle after req at 0x8 -> DROP, imem_addr held 0x8 until ack, 0x8 never output; next out_pc 0x100.
- Redirect to 0x202 coincident with ack and pop, FIFO holding 2 entries -> out_valid=0 next cycle, next imem_addr=0x200, next out_pc 0x200.
- Redirect to 0xFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst asserted mid-wait (req outstanding) -> outputs at reset values without clock edge; ack during reset ignored; after release first imem_addr=RESET_PC.
